keystroke_sequencer: RTL and testbench
======================================

KEYSTROKE_SEQUENCER -- requirements
Module: keystroke_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 5000: cycles after a matched break before the next key is accepted.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum cycles to wait for enc_valid after enc_req.
REQ-003 SHALL use one clock and a synchronous, active-high reset: CLOCK_50 input, 1 bit, rising-edge system clock.
REQ-004 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port rx_data, input, 8 bits: PS/2 scan-code byte from the PS/2 controller.
REQ-006 SHALL have port rx_en, input, 1 bit: one-cycle strobe; rx_data is valid only when it is high.
REQ-007 SHALL have port cfg_busy, input, 1 bit: a rotor-setting button is held, so new key presses are blocked.
REQ-008 SHALL have port enc_valid, input, 1 bit: the cipher core result is valid.
REQ-009 SHALL have port enc_data, input, 8 bits: ASCII ciphertext from the cipher core.
REQ-010 SHALL have port plain_code, output, 8 bits: registered scan code of the accepted key.
REQ-011 SHALL have port enc_req, output, 1 bit: one-cycle pulse requesting an encode of plain_code.
REQ-012 SHALL have port step, output, 1 bit: one-cycle rotor-advance pulse.
REQ-013 SHALL have port cipher_out, output, 8 bits: latched ciphertext for the display and lampboard.
REQ-014 SHALL have port cipher_valid, output, 1 bit: high while cipher_out is to be displayed.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-016 SHALL have port err_timeout, output, 1 bit: sticky flag, set when an encode times out.
REQ-017 SHALL have port state_dbg, output, 3 bits, with the encoding IDLE=0, ENCODE=1, SHOW=2, BREAK=3, HOLD=4.

Function
REQ-018 SHALL implement exactly the states IDLE, ENCODE, SHOW, BREAK and HOLD, all registered.
REQ-019 IDLE: on rx_en, with rx_data not equal to 8'hE0 or 8'hF0 and cfg_busy=0, SHALL latch plain_code<=rx_data, clear the timer, go to ENCODE, and drive enc_req=1 for exactly the first ENCODE cycle.
REQ-020 IDLE: when rx_en arrives with 8'hE0, 8'hF0, or cfg_busy=1, SHALL discard the byte and stay in IDLE.
REQ-021 ENCODE: on enc_valid, SHALL latch cipher_out<=enc_data, set cipher_valid=1, set ok=1, then go to BREAK if brk_pending=1, otherwise to SHOW.
REQ-022 ENCODE: on rx_en with rx_data=8'hF0, SHALL set brk_pending; if enc_valid is high in the same cycle, this counts as pending.
REQ-023 ENCODE: when the timer reaches TIMEOUT_CYCLES-1 without enc_valid, SHALL set err_timeout=1 and ok=0, leave cipher_valid=0, and exit as in REQ-021.
REQ-024 SHALL ignore enc_valid in every state other than ENCODE.
REQ-025 SHOW: on rx_en with rx_data=8'hF0, SHALL go to BREAK; any other byte (typematic repeat, other keys) SHALL be ignored with no re-encode.
REQ-026 BREAK: on rx_en with rx_data==plain_code, SHALL pulse step=1 for one cycle if ok=1, clear the counter, and go to HOLD.
REQ-027 BREAK: on rx_en with any other byte, SHALL return to SHOW.
REQ-028 HOLD: SHALL count 0 to HOLD_CYCLES-1, then go to IDLE, clearing cipher_valid, ok and brk_pending.
REQ-029 HOLD: SHALL discard every rx_en byte.
REQ-030 SHALL produce at most one enc_req and at most one step per accepted key.
REQ-031 SHALL never assert step and enc_req in the same cycle.
REQ-032 SHALL keep cfg_busy sampled only in IDLE, so that asserting it mid-key does not abort the sequence.
REQ-033 SHALL size the counters as ceil(log2) of their parameter, with no wrap-around; the counters saturate only by state exit.

Reset
REQ-034 On reset=1, SHALL on the next edge force IDLE; plain_code=0, cipher_out=0, cipher_valid=0, enc_req=0, step=0, err_timeout=0, ok=0, brk_pending=0, counters=0, state_dbg=0.
REQ-035 Reset SHALL take priority over all inputs, including mid-ENCODE or mid-HOLD; no step pulse SHALL be emitted during or after reset.

Verification
REQ-036 Basic key: rx_en 1C; enc_valid=1 with enc_data=8'h51 three cycles later; then F0, then 1C -> enc_req one pulse; cipher_out=8'h51; cipher_valid=1; one step pulse on the 1C break byte; IDLE after 5000 HOLD cycles.
REQ-037 Typematic repeat: 1C, valid, then 1C 1C 1C, F0, 1C -> exactly one enc_req and one step.
REQ-038 Timeout: 1C with enc_valid never asserted -> err_timeout=1 at cycle 1024 after enc_req; state SHOW; the subsequent F0, 1C gives no step; err_timeout stays 1 until reset.
REQ-039 Blocked key and prefixes: with cfg_busy=1, 1C -> no enc_req, stays IDLE; with cfg_busy=0, E0 or F0 in IDLE -> ignored.
REQ-040 Early break: 1C, then F0 before enc_valid, then enc_valid -> direct ENCODE-to-BREAK transition; then 1C -> step.
REQ-041 Reset mid-HOLD at counter=100 -> all outputs at reset values on the next cycle; a new key 23 is then accepted normally.

Source files
------------

// File: rtl/keystroke_sequencer_if.sv
// PS/2 byte stream, cipher-core handshake and display/lamp outputs of the keystroke sequencer.
interface keystroke_sequencer_if;
  logic [7:0] rx_data;
  logic       rx_en;
  logic       cfg_busy;
  logic       enc_valid;
  logic [7:0] enc_data;
  logic [7:0] plain_code;
  logic       enc_req;
  logic       step;
  logic [7:0] cipher_out;
  logic       cipher_valid;
  logic       busy;
  logic       err_timeout;
  logic [2:0] state_dbg;

  // Environment side: keyboard controller, cipher core and observers
  modport master (
    output rx_data, rx_en, cfg_busy, enc_valid, enc_data,
    input  plain_code, enc_req, step, cipher_out, cipher_valid, busy, err_timeout, state_dbg
  );

  // Sequencer side
  modport slave (
    input  rx_data, rx_en, cfg_busy, enc_valid, enc_data,
    output plain_code, enc_req, step, cipher_out, cipher_valid, busy, err_timeout, state_dbg
  );
endinterface

// File: rtl/keystroke_sequencer.sv
// Turns one PS/2 make/break pair into a single encode request and a single rotor step,
// ignoring typematic repeats and holding off new keys for HOLD_CYCLES after the break.
module keystroke_sequencer #(
  parameter int unsigned HOLD_CYCLES    = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  keystroke_sequencer_if.slave  bus
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ENCODE = 3'd1,
    S_SHOW   = 3'd2,
    S_BREAK  = 3'd3,
    S_HOLD   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    plain_code_q, plain_code_d;
  logic [7:0]    cipher_out_q, cipher_out_d;
  logic          cipher_valid_q, cipher_valid_d;
  logic          enc_req_q, enc_req_d;
  logic          step_q, step_d;
  logic          err_timeout_q, err_timeout_d;
  logic          ok_q, ok_d;
  logic          brk_pending_q, brk_pending_d;
  logic          busy_q, busy_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [HW-1:0] hold_q, hold_d;

  logic rx_brk, key_ok, enc_timeout, brk_seen, hold_done, brk_match;

  assign rx_brk      = bus.rx_en && (bus.rx_data == CODE_BRK);
  assign key_ok      = bus.rx_en && !bus.cfg_busy &&
                       (bus.rx_data != CODE_EXT) && (bus.rx_data != CODE_BRK);
  assign enc_timeout = (timer_q == TW'(TIMEOUT_CYCLES - 1));
  // A break byte arriving alongside enc_valid still counts as pending
  assign brk_seen    = brk_pending_q || rx_brk;
  assign hold_done   = (hold_q == HW'(HOLD_CYCLES - 1));
  assign brk_match   = bus.rx_en && (bus.rx_data == plain_code_q);

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (key_ok) state_d = S_ENCODE;
      S_ENCODE: if (bus.enc_valid || enc_timeout) state_d = brk_seen ? S_BREAK : S_SHOW;
      S_SHOW:   if (rx_brk) state_d = S_BREAK;
      S_BREAK:  if (bus.rx_en) state_d = brk_match ? S_HOLD : S_SHOW;
      S_HOLD:   if (hold_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    plain_code_d   = plain_code_q;
    cipher_out_d   = cipher_out_q;
    cipher_valid_d = cipher_valid_q;
    err_timeout_d  = err_timeout_q;
    ok_d           = ok_q;
    brk_pending_d  = brk_pending_q;
    timer_d        = timer_q;
    hold_d         = hold_q;
    enc_req_d      = 1'b0;
    step_d         = 1'b0;
    busy_d         = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (key_ok) begin
          plain_code_d = bus.rx_data;
          timer_d      = '0;
          enc_req_d    = 1'b1;
        end
      end
      S_ENCODE: begin
        if (rx_brk) brk_pending_d = 1'b1;
        if (bus.enc_valid) begin
          cipher_out_d   = bus.enc_data;
          cipher_valid_d = 1'b1;
          ok_d           = 1'b1;
        end else if (enc_timeout) begin
          err_timeout_d = 1'b1;
          ok_d          = 1'b0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_BREAK: begin
        if (brk_match) begin
          step_d = ok_q;
          hold_d = '0;
        end
      end
      S_HOLD: begin
        if (hold_done) begin
          cipher_valid_d = 1'b0;
          ok_d           = 1'b0;
          brk_pending_d  = 1'b0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      plain_code_q   <= '0;
      cipher_out_q   <= '0;
      cipher_valid_q <= 1'b0;
      enc_req_q      <= 1'b0;
      step_q         <= 1'b0;
      err_timeout_q  <= 1'b0;
      ok_q           <= 1'b0;
      brk_pending_q  <= 1'b0;
      busy_q         <= 1'b0;
      timer_q        <= '0;
      hold_q         <= '0;
    end else begin
      plain_code_q   <= plain_code_d;
      cipher_out_q   <= cipher_out_d;
      cipher_valid_q <= cipher_valid_d;
      enc_req_q      <= enc_req_d;
      step_q         <= step_d;
      err_timeout_q  <= err_timeout_d;
      ok_q           <= ok_d;
      brk_pending_q  <= brk_pending_d;
      busy_q         <= busy_d;
      timer_q        <= timer_d;
      hold_q         <= hold_d;
    end
  end

  assign bus.plain_code   = plain_code_q;
  assign bus.cipher_out   = cipher_out_q;
  assign bus.cipher_valid = cipher_valid_q;
  assign bus.enc_req      = enc_req_q;
  assign bus.step         = step_q;
  assign bus.err_timeout  = err_timeout_q;
  assign bus.busy         = busy_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_keystroke_sequencer.sv
// Directed bench for keystroke_sequencer: make/break sequences, repeats, timeout, blocking, reset.
module tb_keystroke_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   n_req = 0;
  int   n_step = 0;
  logic overlap = 1'b0;

  keystroke_sequencer_if bus();

  keystroke_sequencer #(.HOLD_CYCLES(5000), .TIMEOUT_CYCLES(1024)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Pulse bookkeeping across the whole run
  always @(posedge clk) begin
    if (bus.enc_req) n_req <= n_req + 1;
    if (bus.step) n_step <= n_step + 1;
    if (bus.enc_req && bus.step) overlap <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_en   = 1'b1;
    tick();
    bus.rx_en   = 1'b0;
  endtask

  task automatic valid_pulse(input logic [7:0] d);
    bus.enc_valid = 1'b1;
    bus.enc_data  = d;
    tick();
    bus.enc_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.state_dbg != 3'd0 && n < 20000) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_err(output int n);
    n = 0;
    while (!bus.err_timeout && n < 5000) begin
      tick();
      n++;
    end
  endtask

  int r0, s0, n;

  initial begin
    bus.rx_data   = 8'h00;
    bus.rx_en     = 1'b0;
    bus.cfg_busy  = 1'b0;
    bus.enc_valid = 1'b0;
    bus.enc_data  = 8'h00;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_state", 32'(bus.state_dbg), 0);
    chk("rst_outs", {bus.plain_code, bus.cipher_out, bus.cipher_valid, bus.enc_req,
                     bus.step, bus.err_timeout, bus.busy}, 0);

    // Basic key
    r0 = n_req; s0 = n_step;
    send(8'h1C);
    chk("basic_enc_req", 32'(bus.enc_req), 1);
    chk("basic_plain", 32'(bus.plain_code), 32'h1C);
    chk("basic_encode", 32'(bus.state_dbg), 1);
    chk("basic_busy", 32'(bus.busy), 1);
    tick();
    chk("basic_req_one", 32'(bus.enc_req), 0);
    tick();
    valid_pulse(8'h51);
    chk("basic_show", 32'(bus.state_dbg), 2);
    chk("basic_cipher", 32'(bus.cipher_out), 32'h51);
    chk("basic_cvalid", 32'(bus.cipher_valid), 1);
    valid_pulse(8'h99);
    chk("stray_valid", 32'(bus.cipher_out), 32'h51);
    send(8'hF0);
    chk("basic_break", 32'(bus.state_dbg), 3);
    send(8'h1C);
    chk("basic_step", 32'(bus.step), 1);
    chk("basic_hold", 32'(bus.state_dbg), 4);
    wait_idle(n);
    chk("basic_hold_len", 32'(n), 5000);
    chk("basic_cvalid_clr", 32'(bus.cipher_valid), 0);
    chk("basic_busy_clr", 32'(bus.busy), 0);
    chk("basic_nreq", 32'(n_req - r0), 1);
    chk("basic_nstep", 32'(n_step - s0), 1);

    // Typematic repeat, plus a byte discarded during HOLD
    r0 = n_req; s0 = n_step;
    send(8'h1C);
    tick();
    valid_pulse(8'h51);
    send(8'h1C); send(8'h1C); send(8'h1C);
    chk("rep_show", 32'(bus.state_dbg), 2);
    send(8'hF0);
    send(8'h1C);
    chk("rep_step", 32'(bus.step), 1);
    send(8'h1C);
    chk("rep_hold_discard", 32'(bus.state_dbg), 4);
    wait_idle(n);
    chk("rep_hold_len", 32'(n), 4999);
    chk("rep_nreq", 32'(n_req - r0), 1);
    chk("rep_nstep", 32'(n_step - s0), 1);

    // Timeout
    r0 = n_req; s0 = n_step;
    send(8'h1C);
    chk("to_req", 32'(bus.enc_req), 1);
    wait_err(n);
    chk("to_latency", 32'(n), 1024);
    chk("to_show", 32'(bus.state_dbg), 2);
    chk("to_cvalid", 32'(bus.cipher_valid), 0);
    send(8'hF0);
    send(8'h1C);
    chk("to_hold", 32'(bus.state_dbg), 4);
    chk("to_nostep", 32'(bus.step), 0);
    wait_idle(n);
    chk("to_hold_len", 32'(n), 5000);
    chk("to_nstep", 32'(n_step - s0), 0);
    chk("to_sticky", 32'(bus.err_timeout), 1);

    // Blocked key and prefix bytes
    r0 = n_req;
    bus.cfg_busy = 1'b1;
    send(8'h1C);
    chk("blk_idle", 32'(bus.state_dbg), 0);
    bus.cfg_busy = 1'b0;
    send(8'hE0);
    chk("e0_idle", 32'(bus.state_dbg), 0);
    send(8'hF0);
    chk("f0_idle", 32'(bus.state_dbg), 0);
    chk("blk_nreq", 32'(n_req - r0), 0);

    // Early break: F0 before enc_valid
    s0 = n_step;
    send(8'h1C);
    tick();
    send(8'hF0);
    chk("early_encode", 32'(bus.state_dbg), 1);
    valid_pulse(8'h4B);
    chk("early_break", 32'(bus.state_dbg), 3);
    chk("early_cipher", 32'(bus.cipher_out), 32'h4B);
    send(8'h1C);
    chk("early_step", 32'(bus.step), 1);
    wait_idle(n);
    chk("early_hold_len", 32'(n), 5000);

    // F0 together with enc_valid, then a foreign byte returns to SHOW, cfg_busy mid-key is ignored
    s0 = n_step;
    send(8'h1C);
    bus.cfg_busy  = 1'b1;
    bus.rx_data   = 8'hF0;
    bus.rx_en     = 1'b1;
    bus.enc_valid = 1'b1;
    bus.enc_data  = 8'h33;
    tick();
    bus.rx_en     = 1'b0;
    bus.enc_valid = 1'b0;
    chk("same_break", 32'(bus.state_dbg), 3);
    send(8'h2A);
    chk("other_show", 32'(bus.state_dbg), 2);
    send(8'hF0);
    send(8'h1C);
    chk("same_step", 32'(bus.step), 1);
    bus.cfg_busy = 1'b0;
    wait_idle(n);
    chk("same_nstep", 32'(n_step - s0), 1);

    // Reset in the middle of HOLD
    send(8'h1C);
    valid_pulse(8'h51);
    send(8'hF0);
    send(8'h1C);
    for (int i = 0; i < 100; i++) tick();
    chk("mid_hold", 32'(bus.state_dbg), 4);
    reset = 1'b1;
    tick();
    chk("rst2_state", 32'(bus.state_dbg), 0);
    chk("rst2_outs", {bus.plain_code, bus.cipher_out, bus.cipher_valid, bus.enc_req,
                      bus.step, bus.err_timeout, bus.busy}, 0);
    reset = 1'b0;
    s0 = n_step;
    send(8'h23);
    chk("post_req", 32'(bus.enc_req), 1);
    chk("post_plain", 32'(bus.plain_code), 32'h23);
    valid_pulse(8'h58);
    chk("post_cipher", 32'(bus.cipher_out), 32'h58);
    send(8'hF0);
    send(8'h23);
    chk("post_step", 32'(bus.step), 1);
    wait_idle(n);
    chk("post_hold_len", 32'(n), 5000);
    chk("post_nstep", 32'(n_step - s0), 1);

    chk("no_overlap", 32'(overlap), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
